permutation_host: RTL and testbench
===================================

// Module: permutation_host
// PURPOSE
//  Host-side driver for the Permutation core: owns the Count x (N*N)-bit state
//  buffer, issues start, streams one slice per cycle while the core asserts
//  putInput, captures one result slice per cycle while it asserts ready, and
//  writes results back in place. Sits between the sponge/absorb logic and the core.
// PARAMETERS
//  N        5     matrix side; slice width is N*N bits
//  Count    64    slices per state (lane depth); address width AW = $clog2(Count)
//  TIMEOUT  1024  max cycles waiting for putInput/ready before err is raised
// PORTS
//  clk       in   1      rising-edge clock
//  rst       in   1      asynchronous reset, active-low
//  wrEn      in   1      external slice write strobe (ignored while busy)
//  wrAddr    in   AW     external write slice index
//  wrData    in   N*N    external write slice data
//  rdAddr    in   AW     external read slice index
//  rdData    out  N*N    combinational read of buffer[rdAddr]
//  go        in   1      request one permutation of the buffer (1-cycle pulse)
//  busy      out  1      high from go acceptance until done
//  done      out  1      1-cycle pulse when all Count result slices are written back
//  err       out  1      sticky timeout flag; cleared by next accepted go
//  start     out  1      to core: 1-cycle start pulse
//  in        out  N*N    to core: current slice, buffer[feedIdx]
//  putInput  in   1      from core: core consumes `in` this cycle
//  ready     in   1      from core: `out` is a valid result slice this cycle
//  out       in   N*N    from core: result slice
// BEHAVIOUR
//  Reset (rst=0, async): busy=0, done=0, err=0, start=0, feedIdx=0, colIdx=0,
//   wdog=0, state=IDLE. Buffer contents are not reset.
//  FSM states: IDLE, START, FEED, COLLECT, FIN.
//  IDLE: go=1 -> START. Clears err, feedIdx and colIdx. busy=1 from the next cycle.
//  START: start=1 for exactly one cycle -> FEED.
//  FEED: on each cycle with putInput=1, feedIdx++. The core samples `in` that cycle.
//   After the putInput with feedIdx=Count-1 -> COLLECT.
//  COLLECT: on each cycle with ready=1, buffer[colIdx]<=out and colIdx++.
//   After the write at colIdx=Count-1 -> FIN.
//  FIN: done=1 for one cycle, busy=0 from the next cycle -> IDLE.
//  Gaps: putInput or ready may deassert mid-stream. Indices hold and no slice is
//   skipped or repeated.
//  ready seen in FEED: protocol error. Set err and go to FIN; no write-back.
//  Watchdog: wdog counts cycles in FEED/COLLECT with no putInput/ready and is
//   cleared by each strobe. Reaching TIMEOUT sets err -> FIN (done still pulses).
//  Index wrap: idx is AW bits. Count a power of two; wrap to 0 only via FIN/IDLE.
//  wrEn while busy: dropped, buffer unchanged. wrEn in IDLE writes next edge.
//  go while busy: ignored. go and wrEn in the same IDLE cycle: the write lands
//   before START, so slice 0 is fed with the new value.
//  rdData: read during COLLECT returns the old or new slice per write timing.
//   No forwarding.
//  rst asserted mid-operation: immediate return to IDLE. Core must be reset by
//   the same rst; partially written buffer is left as is.
//  Latency go->done = 3 + feed cycles + collect cycles + core gap (no stalls).
// TESTING
//  1. Load slice i = i (i=0..63), go, core model echoes input -> done once,
//     buffer unchanged, busy high for the whole operation, err=0.
//  2. Core model returns ~in delayed 24 cycles -> buffer[i] = ~i & 25'h1FFFFFF;
//     exactly 64 writes.
//  3. putInput/ready toggled randomly 50% -> same result as case 2,
//     no duplicated or skipped index.
//  4. Core never asserts ready -> err=1 after TIMEOUT idle cycles; done pulses;
//     next go clears err.
//  5. Pulse go and wrEn while busy -> ignored; rst low in COLLECT at colIdx=10
//     -> busy=0, done=0 immediately.
//  6. go with wrAddr=0 wrData=25'h0AAAAAA in the same cycle -> first `in`
//     seen by the core is 25'h0AAAAAA.

Source files
------------

// File: rtl/permutation_host_if.sv
// Core-side link between permutation_host and the Permutation core.
//   start     host -> core  1-cycle start pulse
//   in        host -> core  slice currently offered to the core
//   putInput  core -> host  core consumes `in` this cycle
//   ready     core -> host  `out` holds a valid result slice this cycle
//   out       core -> host  result slice
// Modports: master = host side, slave = core side.
interface permutation_host_if #(
  parameter int W = 25
);
  logic         start;
  logic [W-1:0] in;
  logic         putInput;
  logic         ready;
  logic [W-1:0] out;

  modport master (output start, in, input putInput, ready, out);
  modport slave  (input start, in, output putInput, ready, out);
endinterface

// File: rtl/permutation_host.sv
// Host-side driver for the Permutation core. Owns the Count x (N*N)-bit state
// buffer, launches the core, streams slices out while the core pulls them,
// captures result slices while the core presents them and writes them back in
// place.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   wrEn/wrAddr/wrData  external slice write (honoured only while idle)
//   rdAddr/rdData   combinational read of the buffer
//   go              request one permutation (pulse)
//   busy            operation in progress
//   done            1-cycle pulse when the operation ends
//   err             sticky timeout / protocol error, cleared by the next go
//   core            core link (master side)
module permutation_host #(
  parameter  int N       = 5,
  parameter  int Count   = 64,
  parameter  int TIMEOUT = 1024,
  localparam int W       = N * N,
  localparam int AW      = $clog2(Count)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wrEn,
  input  logic [AW-1:0] wrAddr,
  input  logic [W-1:0]  wrData,
  input  logic [AW-1:0] rdAddr,
  output logic [W-1:0]  rdData,
  input  logic          go,
  output logic          busy,
  output logic          done,
  output logic          err,
  permutation_host_if.master core
);

  localparam int            WDW      = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] LAST     = AW'(Count - 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, START, FEED, COLLECT, FIN} state_t;

  state_t          state, state_d;
  logic [AW-1:0]   feed_idx, feed_idx_d;
  logic [AW-1:0]   col_idx, col_idx_d;
  logic [WDW-1:0]  wdog, wdog_d;
  logic            err_d;
  logic            wb_en;
  logic [W-1:0]    mem [Count];

  // Outputs are plain decodes of the registered state.
  assign busy       = (state != IDLE);
  assign done       = (state == FIN);
  assign core.start = (state == START);
  assign core.in    = mem[feed_idx];
  assign rdData     = mem[rdAddr];

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state;
    feed_idx_d = feed_idx;
    col_idx_d  = col_idx;
    wdog_d     = wdog;
    err_d      = err;
    wb_en      = 1'b0;
    unique case (state)
      IDLE: begin
        if (go) begin
          state_d    = START;
          err_d      = 1'b0;
          feed_idx_d = '0;
          col_idx_d  = '0;
          wdog_d     = '0;
        end
      end
      START: state_d = FEED;
      FEED: begin
        if (core.ready) begin
          // A result before the feed is complete means the core is out of step.
          err_d   = 1'b1;
          state_d = FIN;
        end else if (core.putInput) begin
          wdog_d = '0;
          // Indices saturate at the last slice; only a new go rewinds them.
          if (feed_idx == LAST) state_d = COLLECT;
          else                  feed_idx_d = feed_idx + 1'b1;
        end else if (wdog == WD_LAST) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else begin
          wdog_d = wdog + 1'b1;
        end
      end
      COLLECT: begin
        if (core.ready) begin
          wb_en  = 1'b1;
          wdog_d = '0;
          if (col_idx == LAST) state_d = FIN;
          else                 col_idx_d = col_idx + 1'b1;
        end else if (wdog == WD_LAST) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else begin
          wdog_d = wdog + 1'b1;
        end
      end
      FIN: begin
        state_d = IDLE;
        wdog_d  = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its next value from the same pre-edge snapshot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      feed_idx <= '0;
      col_idx  <= '0;
      wdog     <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_d;
      feed_idx <= feed_idx_d;
      col_idx  <= col_idx_d;
      wdog     <= wdog_d;
      err      <= err_d;
    end
  end

  // NOTE: the buffer has no reset; its contents survive rst and a reset here
  // would turn the array into flops instead of a RAM.
  // External writes land only while idle, so a write in the same cycle as go
  // is in place before the first slice is fed.
  always_ff @(posedge clk) begin
    if (state == IDLE && wrEn) mem[wrAddr]  <= wrData;
    else if (wb_en)            mem[col_idx] <= core.out;
  end

endmodule

// File: tb/tb_permutation_host.sv
module tb_permutation_host;

  localparam int N   = 5;
  localparam int CNT = 64;
  localparam int TO  = 1024;
  localparam int W   = N * N;
  localparam int AW  = $clog2(CNT);

  logic          clk = 1'b0;
  logic          rst;
  logic          wrEn, go;
  logic [AW-1:0] wrAddr, rdAddr;
  logic [W-1:0]  wrData, rdData;
  logic          busy, done, err;

  permutation_host_if #(.W(W)) core_if ();

  permutation_host #(.N(N), .Count(CNT), .TIMEOUT(TO)) dut (
    .clk    (clk),
    .rst    (rst),
    .wrEn   (wrEn),
    .wrAddr (wrAddr),
    .wrData (wrData),
    .rdAddr (rdAddr),
    .rdData (rdData),
    .go     (go),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .core   (core_if)
  );

  always #5 clk = ~clk;

  int           total = 0;
  int           bad   = 0;
  int           done_cnt = 0;
  logic [W-1:0] model [CNT];   // expected buffer contents
  logic [W-1:0] seen  [CNT];   // slices the core model received, in order

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL sim_timeout: bench did not finish, wanted completion");
    $fatal(1);
  end

  // ---------------- helpers ----------------
  task automatic write_slice(input int a, input logic [W-1:0] d);
    wrEn = 1'b1; wrAddr = AW'(a); wrData = d;
    @(negedge clk);
    wrEn = 1'b0;
    model[a] = d;
  endtask

  task automatic check_buffer(input string name);
    int nbad = 0;
    for (int i = 0; i < CNT; i++) begin
      rdAddr = AW'(i);
      #1;
      total++;
      if (rdData !== model[i]) begin
        bad++; nbad++;
        if (nbad <= 4)
          $display("FAIL %s slice %0d: got %h wanted %h", name, i, rdData, model[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic do_go(input bit with_wr, input int a, input logic [W-1:0] d);
    go = 1'b1;
    if (with_wr) begin
      wrEn = 1'b1; wrAddr = AW'(a); wrData = d; model[a] = d;
    end
    @(negedge clk);
    go = 1'b0; wrEn = 1'b0;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (core_if.start === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    total++;
    if (!ok) begin bad++; $display("FAIL start_pulse: start=%b wanted 1", core_if.start); end
  endtask

  // Core model, feed side: pulls CNT slices, optionally with random gaps.
  task automatic feed_phase(input bit gaps);
    int n = 0, cyc = 0;
    bit busy_low = 1'b0, ok = 1'b1;
    @(negedge clk);
    go = 1'b0; wrEn = 1'b0;
    total++;
    if (core_if.start !== 1'b0) begin bad++; $display("FAIL start_width: start=%b wanted 0", core_if.start); end
    while (n < CNT) begin
      if (cyc > 1000) begin ok = 1'b0; break; end
      if (busy !== 1'b1) busy_low = 1'b1;
      core_if.putInput = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (core_if.putInput) begin seen[n] = core_if.in; n++; end
      cyc++;
      @(negedge clk);
    end
    core_if.putInput = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL feed_bound: fed %0d slices wanted %0d", n, CNT); end
    total++;
    if (busy_low) begin bad++; $display("FAIL busy_feed: busy=0 seen wanted 1"); end
  endtask

  // Every slice must reach the core exactly once, in index order.
  task automatic check_feed_order(input string name);
    int first = -1;
    for (int i = 0; i < CNT; i++)
      if (first < 0 && seen[i] !== model[i]) first = i;
    total++;
    if (first >= 0) begin
      bad++;
      $display("FAIL %s index %0d: got %h wanted %h", name, first, seen[first], model[first]);
    end
  endtask

  // Core model, result side: returns f(seen[k]) for k < stop_at.
  task automatic collect_phase(input bit inv, input bit gaps, input int delay, input int stop_at);
    int k = 0, cyc = 0;
    bit busy_low = 1'b0, ok = 1'b1;
    for (int i = 0; i < delay; i++) begin
      if (busy !== 1'b1) busy_low = 1'b1;
      @(negedge clk);
    end
    while (k < stop_at) begin
      if (cyc > 1000) begin ok = 1'b0; break; end
      if (busy !== 1'b1) busy_low = 1'b1;
      core_if.ready = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (core_if.ready) begin
        core_if.out = inv ? ~seen[k] : seen[k];
        k++;
      end else begin
        core_if.out = W'($urandom);   // must not be written back
      end
      cyc++;
      @(negedge clk);
    end
    core_if.ready = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL collect_bound: returned %0d wanted %0d", k, stop_at); end
    total++;
    if (busy_low) begin bad++; $display("FAIL busy_collect: busy=0 seen wanted 1"); end
  endtask

  task automatic check_fin(input string name, input bit exp_err, input int done_before);
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL %s done: got %b wanted 1", name, done); end
    total++;
    if (err !== exp_err) begin bad++; $display("FAIL %s err: got %b wanted %b", name, err, exp_err); end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0)
      begin bad++; $display("FAIL %s idle: busy=%b done=%b wanted 0 0", name, busy, done); end
    total++;
    if (done_cnt - done_before != 1)
      begin bad++; $display("FAIL %s done_count: got %0d wanted 1", name, done_cnt - done_before); end
  endtask

  task automatic apply_result(input bit inv);
    for (int i = 0; i < CNT; i++) if (inv) model[i] = ~model[i];
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, err, core_if.start} !== 4'b0000)
      begin bad++; $display("FAIL reset_outputs: busy/done/err/start=%b wanted 0000", {busy, done, err, core_if.start}); end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle: busy=%b wanted 0", busy); end
  endtask

  task automatic test_echo();
    bit ok; int d0;
    for (int i = 0; i < CNT; i++) write_slice(i, W'(i));
    check_buffer("load");
    d0 = done_cnt;
    do_go(1'b0, 0, '0);
    wait_start(ok);
    if (!ok) return;
    feed_phase(1'b0);
    check_feed_order("echo_feed");
    collect_phase(1'b0, 1'b0, 0, CNT);
    check_fin("echo", 1'b0, d0);
    apply_result(1'b0);
    check_buffer("echo_buf");
  endtask

  task automatic test_invert_delayed();
    bit ok; int d0;
    d0 = done_cnt;
    do_go(1'b0, 0, '0);
    wait_start(ok);
    if (!ok) return;
    feed_phase(1'b0);
    check_feed_order("inv_feed");
    collect_phase(1'b1, 1'b0, 24, CNT);
    check_fin("inv", 1'b0, d0);
    apply_result(1'b1);
    check_buffer("inv_buf");
  endtask

  task automatic test_random_gaps();
    bit ok; int d0;
    for (int i = 0; i < CNT; i++) write_slice(i, W'($urandom));
    d0 = done_cnt;
    do_go(1'b0, 0, '0);
    wait_start(ok);
    if (!ok) return;
    feed_phase(1'b1);
    check_feed_order("gap_feed");
    collect_phase(1'b1, 1'b1, int'($urandom_range(0, 30)), CNT);
    check_fin("gap", 1'b0, d0);
    apply_result(1'b1);
    check_buffer("gap_buf");
  endtask

  task automatic test_timeout();
    bit ok; int d0, cyc;
    d0 = done_cnt;
    do_go(1'b0, 0, '0);
    wait_start(ok);
    if (!ok) return;
    feed_phase(1'b0);
    cyc = 0;
    while (done !== 1'b1 && cyc < TO + 20) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (cyc != TO) begin bad++; $display("FAIL timeout_cycles: got %0d wanted %0d", cyc, TO); end
    check_fin("timeout", 1'b1, d0);
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL err_sticky: err=%b wanted 1", err); end
    check_buffer("timeout_buf");
    // The next accepted go clears err.
    d0 = done_cnt;
    do_go(1'b0, 0, '0);
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL err_clear: err=%b wanted 0", err); end
    wait_start(ok);
    if (!ok) return;
    feed_phase(1'b0);
    collect_phase(1'b0, 1'b0, 0, CNT);
    check_fin("after_timeout", 1'b0, d0);
  endtask

  task automatic test_protocol_err();
    bit ok; int d0;
    d0 = done_cnt;
    do_go(1'b0, 0, '0);
    wait_start(ok);
    if (!ok) return;
    @(negedge clk);             // first FEED cycle
    core_if.ready = 1'b1;
    core_if.out   = W'($urandom);
    @(negedge clk);
    core_if.ready = 1'b0;
    check_fin("proto", 1'b1, d0);
    check_buffer("proto_buf");
  endtask

  task automatic test_busy_ignore_and_reset();
    bit ok; int d0;
    d0 = done_cnt;
    do_go(1'b0, 0, '0);
    wait_start(ok);
    if (!ok) return;
    // Both arrive during START; the feed helper drops them one cycle later.
    go = 1'b1; wrEn = 1'b1; wrAddr = AW'(5); wrData = ~model[5];
    feed_phase(1'b0);
    check_feed_order("busy_feed");
    collect_phase(1'b0, 1'b0, 0, CNT);
    check_fin("busy_ignore", 1'b0, d0);
    check_buffer("busy_buf");
    // Abort mid-collect once slices 0..9 have been written back.
    do_go(1'b0, 0, '0);
    wait_start(ok);
    if (!ok) return;
    feed_phase(1'b0);
    collect_phase(1'b1, 1'b0, 0, 10);
    rst = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0)
      begin bad++; $display("FAIL rst_abort: busy=%b done=%b wanted 0 0", busy, done); end
    for (int i = 0; i < 10; i++) model[i] = ~model[i];
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_buffer("abort_buf");
  endtask

  task automatic test_go_with_write();
    bit ok; int d0;
    logic [W-1:0] pat;
    pat = 25'h0AAAAAA;
    d0 = done_cnt;
    do_go(1'b1, 0, pat);
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL go_clears_err: err=%b wanted 0", err); end
    wait_start(ok);
    if (!ok) return;
    feed_phase(1'b0);
    total++;
    if (seen[0] !== pat) begin bad++; $display("FAIL go_write_first: got %h wanted %h", seen[0], pat); end
    check_feed_order("gowr_feed");
    collect_phase(1'b0, 1'b0, 0, CNT);
    check_fin("gowr", 1'b0, d0);
    check_buffer("gowr_buf");
  endtask

  initial begin
    rst = 1'b0; wrEn = 1'b0; go = 1'b0;
    wrAddr = '0; wrData = '0; rdAddr = '0;
    core_if.putInput = 1'b0; core_if.ready = 1'b0; core_if.out = '0;
    @(negedge clk);
    test_reset();
    test_echo();
    test_invert_delayed();
    test_random_gaps();
    test_timeout();
    test_protocol_err();
    test_busy_ignore_and_reset();
    test_go_with_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
